subbytes_shiftrows_seq: RTL and testbench
=========================================

Name: subbytes_shiftrows_seq

Overview:
- Round-datapath stage directly upstream of mixcolumns.
- Takes a 128-bit AES state and applies SubBytes (FIPS-197 S-box) in byte groups over several cycles, then ShiftRows.
- Presents the result on a valid/ready output that feeds the mixcolumns input (cyphertext_temp_i).
- Sequential byte-group processing trades S-box area against latency.

Parameters:
- SBOX_PER_CYCLE, 4, S-box instances used per cycle; legal values 1, 2, 4, 8, 16; NGRP = 16/SBOX_PER_CYCLE cycles per block.
- Widths use `TEXT_WIDTH (128) and `BYTE_WIDTH (8).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  state_i holds a valid state
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready at a rising edge
- state_i  in  `TEXT_WIDTH  input state; byte k at [127-8k -: 8]; column-major (k = 4*col + row)
- out_valid  out  1  state_o valid
- out_ready  in  1  downstream consumes; transfer occurs when out_valid && out_ready
- state_o  out  `TEXT_WIDTH  ShiftRows(SubBytes(state_i)), same byte ordering; registered
- busy  out  1  high in SUB or HOLD

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, out_valid=0, state_o=0, busy=0, group counter=0, work register=0.
- in_ready is combinational: 1 in IDLE; out_ready in HOLD; 0 in SUB.
- FSM states: IDLE, SUB, HOLD.
- IDLE + accept: load state_i into the work register, counter=0, go to SUB.
- SUB, each cycle:
  - Replace bytes g*N .. g*N+N-1 of the work register with S(byte), where g = counter and N = SBOX_PER_CYCLE.
  - counter++.
  - When g = NGRP-1, on the same edge:
    - state_o <= ShiftRows(fully substituted work register);
    - out_valid <= 1;
    - go to HOLD.
- ShiftRows: out byte (row r, col c) = sub byte (row r, col (c+r) mod 4); row 0 is unchanged.
- Latency: out_valid rises on the (NGRP+1)th rising edge after the accepting edge counts as edge 0. For N=4, the accept edge is followed by 4 SUB edges, and out_valid is seen high 4 cycles after accept. In general the gap is NGRP cycles.
- HOLD:
  - state_o and out_valid are stable while out_ready=0.
  - On out_ready=1 with in_valid=1: the output transfers and the new input is accepted on the same edge. out_valid <= 0, go to SUB with counter=0. Back-to-back throughput is one block per NGRP+1 cycles.
  - On out_ready=1 with in_valid=0: out_valid <= 0, go to IDLE.
- state_i is sampled only on the accept edge; later changes are ignored.
- in_valid while in SUB is ignored; it is not accepted and not lost from the upstream view, since in_ready=0.
- S-box: standard FIPS-197 forward S-box, bit-exact. ROM or composite-field implementation is allowed but must be purely combinational inside the SUB cycle.
- Reset mid-operation (SUB or HOLD): an in-flight block is discarded; all outputs return to reset values immediately (asynchronous).
- Single-group configuration (N=16, NGRP=1): SUB lasts exactly one cycle.

Test Plan:
- Reset check: assert rst_n=0 mid-SUB -> out_valid=0, state_o=0, busy=0, in_ready=1 asynchronously; no output after release.
- FIPS-197 App. B round 1 vector:
  - Stimulus: state_i=193de3be_a0f4e22b_9ac68d2a_e9f84808 with out_ready=1.
  - Required response: state_o=d4bf5d30_e0b452ae_b84111f1_1e2798e5.
  - Required timing: out_valid for exactly one cycle, 4 cycles after accept (N=4).
- All-zero input -> state_o=63636363_63636363_63636363_63636363; input 0x53 in every byte -> every output byte 0xed.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD -> state_o and out_valid stable, in_ready=0; on release, the output transfers, and a pending in_valid is accepted on the same edge.
- Exhaustive S-box check:
  - Stimulus: 16 back-to-back blocks covering bytes 0x00-0xff (block b byte k = 16b+k), random out_ready.
  - Required response: every output matches the golden ShiftRows(SubBytes()) model, with no drops or duplicates.
- Parameter sweep: SBOX_PER_CYCLE = 1, 2, 8, 16 rerunning the App. B vector -> same state_o; latency NGRP = 16, 8, 2, 1 cycles.

Source files
------------

// File: rtl/subbytes_shiftrows_seq.sv
// AES round stage: SubBytes applied SBOX_PER_CYCLE bytes per cycle, then ShiftRows,
// delivered on a registered valid/ready output that feeds mixcolumns.
`ifndef TEXT_WIDTH
`define TEXT_WIDTH 128
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif

module subbytes_shiftrows_seq #(
  parameter int SBOX_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [`TEXT_WIDTH-1:0] state_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [`TEXT_WIDTH-1:0] state_o,
  output logic                   busy
);

  localparam int TW    = `TEXT_WIDTH;
  localparam int BW    = `BYTE_WIDTH;
  localparam int NGRP  = 16 / SBOX_PER_CYCLE;
  localparam int CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NGRP - 1);

  typedef enum logic [1:0] {IDLE, SUB, HOLD} fsm_t;

  fsm_t                      state, state_nx;
  logic [CNT_W-1:0]          cnt, cnt_nx;
  logic signed [TW-1:0]      work, work_nx, work_sub;
  logic signed [TW-1:0]      out_nx;
  logic                      ov_nx;

  function automatic logic [BW-1:0] xtime(input logic [BW-1:0] a);
    return {a[BW-2:0], 1'b0} ^ (a[BW-1] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BW-1:0] gf_mul(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW-1:0] p;
    logic [BW-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < BW; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
  function automatic logic [BW-1:0] gf_inv(input logic [BW-1:0] a);
    logic [BW-1:0] x;
    logic [BW-1:0] r;
    x = a;
    r = 8'h01;
    for (int i = 1; i < BW; i++) begin
      x = gf_mul(x, x);
      r = gf_mul(r, x);
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] sbox(input logic [BW-1:0] a);
    logic [BW-1:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Byte k = 4*col + row; row r rotates left by r columns.
  function automatic logic [TW-1:0] shift_rows(input logic [TW-1:0] s);
    logic [TW-1:0] o;
    int src;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      src = 4 * (((k / 4) + (k % 4)) % 4) + (k % 4);
      o[TW-1-BW*k -: BW] = s[TW-1-BW*src -: BW];
    end
    return o;
  endfunction

  always_comb begin
    int idx;
    idx      = 0;
    work_sub = work;
    for (int j = 0; j < SBOX_PER_CYCLE; j++) begin
      idx = int'(cnt) * SBOX_PER_CYCLE + j;
      work_sub[TW-1-BW*idx -: BW] = sbox(work[TW-1-BW*idx -: BW]);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    work_nx  = work;
    out_nx   = state_o;
    ov_nx    = out_valid;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_nx  = state_i;
          cnt_nx   = '0;
          state_nx = SUB;
        end
      end
      SUB: begin
        work_nx = work_sub;
        cnt_nx  = cnt + CNT_W'(1);
        if (cnt == LAST_GRP) begin
          out_nx   = shift_rows(work_sub);
          ov_nx    = 1'b1;
          cnt_nx   = '0;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          ov_nx = 1'b0;
          if (in_valid) begin
            work_nx  = state_i;
            cnt_nx   = '0;
            state_nx = SUB;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Work and output registers are cleared too so an aborted block leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      state_o   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      work      <= work_nx;
      state_o   <= out_nx;
      out_valid <= ov_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_subbytes_shiftrows_seq.sv
// Scoreboard bench for subbytes_shiftrows_seq: directed FIPS-197 vectors, backpressure,
// async reset, exhaustive S-box coverage and an SBOX_PER_CYCLE sweep.
module tb_subbytes_shiftrows_seq;

  localparam logic [127:0] APPB_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
  localparam logic [127:0] APPB_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] ZERO_OUT = {16{8'h63}};
  localparam logic [127:0] X53_OUT  = {16{8'hed}};

  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_i = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] state_o;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int received = 0;
  int sent = 0;
  logic rand_en = 1'b0;
  logic [127:0] exp_q[$];

  logic         sw_iv[4];
  logic         sw_ir[4];
  logic         sw_ov[4];
  logic         sw_busy[4];
  logic [127:0] sw_so[4];
  logic [127:0] sw_si = '0;
  logic         sw_or = 1'b1;

  always #5 clk = ~clk;

  subbytes_shiftrows_seq #(.SBOX_PER_CYCLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .state_i(state_i), .out_valid(out_valid), .out_ready(out_ready),
    .state_o(state_o), .busy(busy));

  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    localparam int N = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 16;
    subbytes_shiftrows_seq #(.SBOX_PER_CYCLE(N)) u_sw (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[gi]), .in_ready(sw_ir[gi]),
      .state_i(sw_si), .out_valid(sw_ov[gi]), .out_ready(sw_or),
      .state_o(sw_so[gi]), .busy(sw_busy[gi]));
  end

  function automatic logic [7:0] tb_sbox(input logic [7:0] b);
    logic [2047:0] t;
    t = SBOX_T;
    return t[2047 - 8*b -: 8];
  endfunction

  function automatic logic [127:0] golden(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = tb_sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer pops one expected block.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      received++;
      if (exp_q.size() == 0) chk("unexpected_output", state_o, 128'h0 ^ {128{1'bx}});
      else chk("scoreboard", state_o, exp_q.pop_front());
    end
  end

  always @(posedge clk) begin
    if (rand_en) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [127:0] s, input logic [127:0] e);
    int n;
    logic rdy;
    n = 0;
    in_valid = 1'b1;
    state_i  = s;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    if (!rdy) chk("accept_timeout", 128'd0, 128'd1);
    else begin
      exp_q.push_back(e);
      sent++;
    end
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    logic [127:0] v;
    int lat;
    for (int i = 0; i < 4; i++) sw_iv[i] = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_state_o", state_o, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // App. B vector with latency and single-cycle valid
    send(APPB_IN, APPB_OUT);
    in_valid = 1'b0;
    state_i  = '0;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) chk("sub_in_ready", 128'(in_ready), 128'd0);
      chk($sformatf("appb_valid_c%0d", j), 128'(out_valid), (j == 4) ? 128'd1 : 128'd0);
    end
    wait_drain();

    send('0, ZERO_OUT);
    in_valid = 1'b0;
    send({16{8'h53}}, X53_OUT);
    in_valid = 1'b0;
    wait_drain();

    // Backpressure: hold output, pending input waits
    out_ready = 1'b0;
    send(APPB_IN, APPB_OUT);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_valid_rise", 128'(out_valid), 128'd1);
    in_valid = 1'b1;
    state_i  = '0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("bp_hold_valid", 128'(out_valid), 128'd1);
      chk("bp_hold_data", state_o, APPB_OUT);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    exp_q.push_back(ZERO_OUT);
    sent++;
    #1;
    in_valid = 1'b0;
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_accept_busy", 128'(busy), 128'd1);
    chk("bp_accept_in_ready", 128'(in_ready), 128'd0);
    wait_drain();

    // Asynchronous reset in the middle of SUB
    in_valid = 1'b1;
    state_i  = APPB_IN;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_rst_busy", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_state_o", state_o, 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_idle", 128'(busy), 128'd0);

    // Exhaustive S-box: 16 back-to-back blocks with random backpressure
    rand_en = 1'b1;
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) v[127 - 8*k -: 8] = 8'(16*b + k);
      send(v, golden(v));
    end
    in_valid = 1'b0;
    rand_en  = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();
    chk("no_drop_dup", 128'(received), 128'(sent));

    // SBOX_PER_CYCLE sweep: 1, 2, 8, 16 -> NGRP 16, 8, 2, 1
    for (int i = 0; i < 4; i++) begin
      sw_si    = APPB_IN;
      sw_iv[i] = 1'b1;
      @(posedge clk);
      #1;
      sw_iv[i] = 1'b0;
      sw_si    = '0;
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!sw_ov[i] && lat < 40);
      chk($sformatf("sweep%0d_latency", i), 128'(lat), 128'(16 / ((i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 8 : 16)));
      chk($sformatf("sweep%0d_state_o", i), sw_so[i], APPB_OUT);
      @(posedge clk);
      #1;
      chk($sformatf("sweep%0d_valid_drop", i), 128'(sw_ov[i]), 128'd0);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

endmodule
